reg_wb_scheduler: RTL and testbench
===================================

// Module: reg_wb_scheduler
// PURPOSE
//  Schedules the single register-file write port between the 1-cycle ALU write-back path and the multi-cycle MUL/DIV unit.
//  Tracks MUL/DIV destinations that are still in flight and raises HAZARD to decode.
//  Forces a pipeline stall when the MUL/DIV result has been blocked too long.
//  Sits between the EX/MEM/WB pipeline and reg_file; drives its WRITE_ENABLE/WRITE_ADDRESS/WRITE_DATA.
// PARAMETERS
//  DATA_WIDTH  32  write-back data width
//  ADDR_WIDTH  5   register index width (32 registers; x0 hard-wired zero)
//  MAX_WAIT    4   cycles MUL/DIV may be denied before stall is forced (>=1)
// PORTS
//  CLK            in   1   clock; all state updates on posedge
//  RESET          in   1   synchronous, active-low reset
//  ALU_WB_VALID   in   1   ALU result present this cycle (no back-pressure)
//  ALU_WB_ADDR    in   5   ALU destination register
//  ALU_WB_DATA    in   32  ALU result
//  MD_WB_VALID    in   1   MUL/DIV result offered (held until accepted)
//  MD_WB_ADDR     in   5   MUL/DIV destination register
//  MD_WB_DATA     in   32  MUL/DIV result
//  MD_WB_READY    out  1   MUL/DIV result accepted this cycle (handshake = VALID & READY)
//  ISSUE_MD       in   1   MUL/DIV instruction issued this cycle
//  ISSUE_RD       in   5   its destination register
//  DEC_RS1/DEC_RS2/DEC_RD in 5 each  decode-stage register indices
//  HAZARD         out  1   decode must stall: a decode index is pending (combinational)
//  PIPE_STALL     out  1   freeze pipeline (high only in FORCE)
//  WRITE_ENABLE   out  1   reg_file write enable (registered)
//  WRITE_ADDRESS  out  5   reg_file write index (registered)
//  WRITE_DATA     out  32  reg_file write data (registered)
// BEHAVIOUR
//  Reset (RESET==0 at posedge): state=IDLE; wait_cnt=0; all pending bits=0; WRITE_*=0. Outputs during reset: PIPE_STALL=0, HAZARD=0.
//  Reset mid-operation drops any un-accepted MUL/DIV result. The MUL/DIV unit is reset by the same RESET.
//  FSM is IDLE / WAIT / FORCE.
//   IDLE : ALU_WB_VALID -> grant ALU.
//          Otherwise MD_WB_VALID -> grant MD (MD_WB_READY=1).
//          If both are valid: ALU is granted, wait_cnt=1, next state WAIT.
//   WAIT : grant MD if ALU_WB_VALID=0 -> IDLE, wait_cnt=0.
//          Otherwise ALU is granted and wait_cnt++. When wait_cnt==MAX_WAIT -> FORCE.
//   FORCE: PIPE_STALL=1. MD is granted unconditionally; ALU_WB_* is ignored (the frozen pipeline holds it). Next state IDLE.
//  Grant in cycle N -> WRITE_* presented in cycle N+1 (1-cycle latency). No grant -> WRITE_ENABLE=0 in N+1.
//  Granted address 0 -> WRITE_ENABLE=0. The handshake still completes.
//  MD must hold MD_WB_VALID/ADDR/DATA stable until accepted. Deasserting VALID before acceptance is a protocol error; the FSM then returns to IDLE.
//  Scoreboard (32 pending bits, bit 0 constant 0):
//   - ISSUE_MD sets pending[ISSUE_RD].
//   - An MD handshake clears pending[MD_WB_ADDR].
//   - Set and clear of the same index in one cycle: set wins.
//  HAZARD = pending[DEC_RS1] | pending[DEC_RS2] | pending[DEC_RD]. Decode never issues a WAW to a pending rd.
// CONFIGURATION
//  Macro REG_WB_BYPASS_EN adds outputs BYPASS_HIT (1) and BYPASS_DATA (32).
//   Defined: in the MD handshake cycle, a decode index equal to MD_WB_ADDR (non-zero) is not counted in HAZARD that cycle.
//            BYPASS_HIT=1 and BYPASS_DATA=MD_WB_DATA, combinational. Otherwise BYPASS_HIT=0 and BYPASS_DATA=0.
//   Undefined: no bypass ports. HAZARD clears the cycle after the handshake.
// STRUCTURE
//  Package reg_sched_pkg holds:
//   - the state typedef: IDLE=2'b00, WAIT=2'b01, FORCE=2'b10
//   - DATA_WIDTH/ADDR_WIDTH defaults and the x0 index constant
//  Sub-module reg_scoreboard holds the pending bits, set/clear logic and HAZARD compare.
//  The top level holds the FSM, wait counter, grant mux and output registers.
// TESTING
//  1. Reset sequence: RESET low 2 cycles, then high -> WRITE_ENABLE=0, PIPE_STALL=0, HAZARD=0.
//  2. ALU only: ALU_WB_VALID=1, ADDR=1, DATA=10 in cycle N -> WRITE_EN=1, ADDR=1, DATA=10 in N+1.
//     Same with ADDR=0 -> WRITE_EN=0.
//  3. Contention, MAX_WAIT=4: MD valid (x5, 0xDEAD) with ALU valid for 3 cycles, then ALU idle
//     -> MD accepted on cycle 4, no PIPE_STALL, x5 written next cycle.
//  4. Starvation: ALU valid continuously with MD valid -> after 4 denials PIPE_STALL=1 for exactly 1 cycle.
//     MD is accepted that cycle; the held ALU write lands the following cycle.
//  5. Scoreboard: ISSUE_MD rd=7 -> HAZARD with DEC_RS1=7 until the MD handshake on x7.
//     HAZARD then drops: next cycle without REG_WB_BYPASS_EN, same cycle with BYPASS_HIT=1.
//     ISSUE_RD=0 never raises HAZARD.
//  6. Reset during WAIT with MD valid -> after reset state=IDLE, pending=0, no write of the dropped result.

Source files
------------

// File: rtl/reg_wb_scheduler_pkg.sv
// reg_sched_pkg: shared types and constants for the register write-back
// scheduler.
//   state_e      : arbitration FSM state (IDLE / WAIT / FORCE)
//   *_WIDTH_DEF  : default data/index widths
//   X0_IDX       : index of the hard-wired zero register
package reg_sched_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int X0_IDX         = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    FORCE = 2'b10
  } state_e;

endpackage

// File: rtl/reg_wb_scheduler_scoreboard.sv
// reg_scoreboard: one pending bit per register for MUL/DIV destinations that
// are still in flight, plus the decode hazard compare.
//   i_clk, i_reset        : clock, synchronous active-low reset
//   i_set_en / i_set_idx  : MUL/DIV issue marks its destination pending
//   i_clr_en / i_clr_idx  : MUL/DIV handshake retires its destination
//   i_byp_en              : the retiring index is forwarded this cycle, so it
//                           does not count as a hazard
//   i_rs1, i_rs2, i_rd    : decode-stage indices
//   o_hazard              : a decode index is pending (combinational)
module reg_scoreboard
  import reg_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_set_en,
  input  logic [ADDR_WIDTH-1:0] i_set_idx,
  input  logic                  i_clr_en,
  input  logic [ADDR_WIDTH-1:0] i_clr_idx,
  input  logic                  i_byp_en,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  input  logic [ADDR_WIDTH-1:0] i_rs2,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  output logic                  o_hazard
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_hit1, w_hit2, w_hitd;

  // Clear is applied first so a same-cycle set of the same index wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_en) w_pending_nxt[i_clr_idx] = 1'b0;
    if (i_set_en) w_pending_nxt[i_set_idx] = 1'b1;
    w_pending_nxt[X0_IDX] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_pending <= '0;
    else          r_pending <= w_pending_nxt;
  end

  // An index being forwarded this cycle is masked out of the compare.
  assign w_hit1 = r_pending[i_rs1] & ~(i_byp_en & (i_rs1 == i_clr_idx));
  assign w_hit2 = r_pending[i_rs2] & ~(i_byp_en & (i_rs2 == i_clr_idx));
  assign w_hitd = r_pending[i_rd]  & ~(i_byp_en & (i_rd  == i_clr_idx));

  assign o_hazard = i_reset & (w_hit1 | w_hit2 | w_hitd);

endmodule

// File: rtl/reg_wb_scheduler.sv
// reg_wb_scheduler: arbitrates the single register-file write port between
// the 1-cycle ALU write-back and the multi-cycle MUL/DIV result, tracks
// in-flight MUL/DIV destinations and forces a pipeline stall when MUL/DIV
// has been starved for MAX_WAIT cycles.
//   i_clk, i_reset               : clock, synchronous active-low reset
//   i_alu_wb_valid/addr/data     : ALU result (no back-pressure)
//   i_md_wb_valid/addr/data      : MUL/DIV result, held until accepted
//   o_md_wb_ready                : MUL/DIV accepted when valid & ready
//   i_issue_md / i_issue_rd      : MUL/DIV issue and its destination
//   i_dec_rs1/rs2/rd             : decode-stage indices
//   o_hazard                     : decode must stall (combinational)
//   o_pipe_stall                 : pipeline freeze, high only in FORCE
//   o_write_enable/address/data  : registered reg_file write port
// Optional macro REG_WB_BYPASS_EN adds o_bypass_hit / o_bypass_data, which
// forward the MUL/DIV result to decode in its handshake cycle.
module reg_wb_scheduler
  import reg_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0] i_alu_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_alu_wb_data,
  input  logic                  i_md_wb_valid,
  input  logic [ADDR_WIDTH-1:0] i_md_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_md_wb_data,
  output logic                  o_md_wb_ready,
  input  logic                  i_issue_md,
  input  logic [ADDR_WIDTH-1:0] i_issue_rd,
  input  logic [ADDR_WIDTH-1:0] i_dec_rs1,
  input  logic [ADDR_WIDTH-1:0] i_dec_rs2,
  input  logic [ADDR_WIDTH-1:0] i_dec_rd,
  output logic                  o_hazard,
  output logic                  o_pipe_stall,
  output logic                  o_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_address,
  output logic [DATA_WIDTH-1:0] o_write_data
`ifdef REG_WB_BYPASS_EN
  ,
  output logic                  o_bypass_hit,
  output logic [DATA_WIDTH-1:0] o_bypass_data
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(X0_IDX);

  state_e         r_state;
  logic [CW-1:0]  r_wait_cnt;
  logic [CW-1:0]  w_cnt_inc;
  logic           w_force, w_alu_gnt, w_md_rdy, w_md_hs, w_byp_en;

  // In FORCE the frozen pipeline holds the ALU result, so only MD is served.
  assign w_force   = (r_state == FORCE);
  assign w_alu_gnt = i_reset & i_alu_wb_valid & ~w_force;
  assign w_md_rdy  = i_reset & (w_force | ~i_alu_wb_valid);
  assign w_md_hs   = w_md_rdy & i_md_wb_valid;
  assign w_cnt_inc = r_wait_cnt + 1'b1;

  assign o_md_wb_ready = w_md_rdy;
  assign o_pipe_stall  = i_reset & w_force;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state         <= IDLE;
      r_wait_cnt      <= '0;
      o_write_enable  <= 1'b0;
      o_write_address <= '0;
      o_write_data    <= '0;
    end else begin
      // Write port: x0 completes the grant but never writes.
      if (w_alu_gnt) begin
        o_write_enable  <= (i_alu_wb_addr != X0);
        o_write_address <= i_alu_wb_addr;
        o_write_data    <= i_alu_wb_data;
      end else if (w_md_hs) begin
        o_write_enable  <= (i_md_wb_addr != X0);
        o_write_address <= i_md_wb_addr;
        o_write_data    <= i_md_wb_data;
      end else begin
        o_write_enable  <= 1'b0;
        o_write_address <= '0;
        o_write_data    <= '0;
      end

      case (r_state)
        IDLE: begin
          if (i_alu_wb_valid && i_md_wb_valid) begin
            r_wait_cnt <= CW'(1);
            r_state    <= (MAX_WAIT == 1) ? FORCE : WAIT;
          end
        end
        WAIT: begin
          // MD served, or MD dropped its offer: either way back to IDLE.
          if (!i_alu_wb_valid || !i_md_wb_valid) begin
            r_wait_cnt <= '0;
            r_state    <= IDLE;
          end else begin
            r_wait_cnt <= w_cnt_inc;
            if (w_cnt_inc == CW'(MAX_WAIT)) r_state <= FORCE;
          end
        end
        FORCE: begin
          r_wait_cnt <= '0;
          r_state    <= IDLE;
        end
        default: begin
          r_wait_cnt <= '0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

`ifdef REG_WB_BYPASS_EN
  logic w_byp_hit;
  assign w_byp_en  = w_md_hs & (i_md_wb_addr != X0);
  assign w_byp_hit = w_byp_en & ((i_dec_rs1 == i_md_wb_addr) |
                                 (i_dec_rs2 == i_md_wb_addr) |
                                 (i_dec_rd  == i_md_wb_addr));
  assign o_bypass_hit  = w_byp_hit;
  assign o_bypass_data = w_byp_hit ? i_md_wb_data : '0;
`else
  assign w_byp_en = 1'b0;
`endif

  reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_set_en  (i_issue_md),
    .i_set_idx (i_issue_rd),
    .i_clr_en  (w_md_hs),
    .i_clr_idx (i_md_wb_addr),
    .i_byp_en  (w_byp_en),
    .i_rs1     (i_dec_rs1),
    .i_rs2     (i_dec_rs2),
    .i_rd      (i_dec_rd),
    .o_hazard  (o_hazard)
  );

endmodule

// File: tb/tb_reg_wb_scheduler.sv
module tb_reg_wb_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_v, md_v, issue;
  logic [AW-1:0] alu_a, md_a, issue_rd, rs1, rs2, rd;
  logic [DW-1:0] alu_d, md_d;
  logic          md_rdy, hazard, stall, we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
`ifdef REG_WB_BYPASS_EN
  logic          byp_hit;
  logic [DW-1:0] byp_data;
`endif

  always #5 clk = ~clk;

  reg_wb_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_alu_wb_valid(alu_v), .i_alu_wb_addr(alu_a), .i_alu_wb_data(alu_d),
    .i_md_wb_valid(md_v), .i_md_wb_addr(md_a), .i_md_wb_data(md_d),
    .o_md_wb_ready(md_rdy),
    .i_issue_md(issue), .i_issue_rd(issue_rd),
    .i_dec_rs1(rs1), .i_dec_rs2(rs2), .i_dec_rd(rd),
    .o_hazard(hazard), .o_pipe_stall(stall),
    .o_write_enable(we), .o_write_address(wa), .o_write_data(wd)
`ifdef REG_WB_BYPASS_EN
    , .o_bypass_hit(byp_hit), .o_bypass_data(byp_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: set of in-flight registers, count of consecutive
  // cycles an MD offer has lost to the ALU, and the expected write port.
  bit [31:0]     m_pend;
  int            m_denied;
  bit            m_we;
  bit [AW-1:0]   m_wa;
  bit [DW-1:0]   m_wd;
  bit            md_have;
  logic          obs_stall, obs_haz;
  int            stall_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pend_hit(input logic [AW-1:0] idx, input bit byp, input logic [AW-1:0] ba);
    return m_pend[idx] && !(byp && idx == ba);
  endfunction

  // One clock: combinational outputs checked mid-cycle against the model,
  // registered outputs checked just after the edge.
  task automatic cycle();
    bit frc, alu_g, md_g, byp, exp_haz, exp_hit;
    frc   = rst && (m_denied == MAX_WAIT);
    alu_g = rst && alu_v && !frc;
    md_g  = rst && md_v && (frc || !alu_v);
`ifdef REG_WB_BYPASS_EN
    byp = md_g && (md_a != 0);
`else
    byp = 1'b0;
`endif
    exp_haz = rst && (pend_hit(rs1, byp, md_a) || pend_hit(rs2, byp, md_a) || pend_hit(rd, byp, md_a));
    exp_hit = byp && (rs1 == md_a || rs2 == md_a || rd == md_a);
    @(negedge clk);
    obs_stall = stall;
    obs_haz   = hazard;
    if (stall === 1'b1) stall_seen++;
    chk("pipe_stall", stall, {31'b0, frc});
    chk("hazard", hazard, {31'b0, exp_haz});
    if (rst && md_v) chk("md_ready", md_rdy, {31'b0, md_g});
`ifdef REG_WB_BYPASS_EN
    chk("bypass_hit", byp_hit, {31'b0, exp_hit});
    chk("bypass_data", byp_data, exp_hit ? md_d : 32'd0);
`else
    if (exp_hit) chk("no_bypass", 32'd1, 32'd0);
`endif
    @(posedge clk);
    #1;
    if (!rst) begin
      m_pend = '0; m_denied = 0; m_we = 0; m_wa = '0; m_wd = '0;
      md_have = 0;
    end else begin
      if (alu_g)     begin m_we = (alu_a != 0); m_wa = alu_a; m_wd = alu_d; end
      else if (md_g) begin m_we = (md_a != 0);  m_wa = md_a;  m_wd = md_d;  end
      else           m_we = 0;
      if (md_g) begin m_pend[md_a] = 1'b0; md_have = 0; end
      if (issue) m_pend[issue_rd] = 1'b1;
      m_pend[0] = 1'b0;
      if (frc) m_denied = 0;
      else if (alu_v && md_v) m_denied++;
      else m_denied = 0;
    end
    chk("write_enable", we, {31'b0, m_we});
    if (m_we) begin
      chk("write_address", {27'b0, wa}, {27'b0, m_wa});
      chk("write_data", wd, m_wd);
    end
  endtask

  initial begin
    rst = 0; alu_v = 0; alu_a = 0; alu_d = 0; md_v = 0; md_a = 0; md_d = 0;
    issue = 0; issue_rd = 0; rs1 = 0; rs2 = 0; rd = 0;
    m_pend = '0; m_denied = 0; m_we = 0; m_wa = 0; m_wd = 0; md_have = 0;
    stall_seen = 0;
    #1;

    // Reset sequence
    cycle(); cycle();
    rst = 1;
    chk("reset_we", we, 32'd0);

    // ALU only
    alu_v = 1; alu_a = 1; alu_d = 10;
    cycle();
    chk("alu_we", we, 32'd1);
    chk("alu_addr", {27'b0, wa}, 32'd1);
    chk("alu_data", wd, 32'd10);
    alu_a = 0; alu_d = 99;
    cycle();
    chk("alu_x0_we", we, 32'd0);

    // Contention resolved before starvation
    md_v = 1; md_a = 5; md_d = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      alu_a = AW'(10 + i); alu_d = 32'h100 + i;
      cycle();
    end
    alu_v = 0;
    stall_seen = 0;
    cycle();
    chk("cont_no_stall", stall_seen, 32'd0);
    chk("cont_md_we", we, 32'd1);
    chk("cont_md_addr", {27'b0, wa}, 32'd5);
    chk("cont_md_data", wd, 32'hDEAD);
    md_v = 0;

    // Starvation: four denials, then one FORCE cycle
    md_v = 1; md_a = 6; md_d = 32'hBEEF;
    alu_v = 1; alu_a = 3; alu_d = 32'h33;
    stall_seen = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("starve_pre", stall_seen, 32'd0);
    cycle();
    chk("force_stall", obs_stall, 32'd1);
    chk("force_md_addr", {27'b0, wa}, 32'd6);
    chk("force_md_data", wd, 32'hBEEF);
    md_v = 0;
    cycle();
    chk("held_alu_addr", {27'b0, wa}, 32'd3);
    chk("held_alu_data", wd, 32'h33);
    chk("stall_once", stall_seen, 32'd1);
    alu_v = 0;
    cycle();

    // Scoreboard
    issue = 1; issue_rd = 7;
    cycle();
    issue = 0; rs1 = 7;
    cycle();
    chk("sb_hazard", obs_haz, 32'd1);
    md_v = 1; md_a = 7; md_d = 32'h77;
    cycle();
`ifdef REG_WB_BYPASS_EN
    chk("sb_hs_haz", obs_haz, 32'd0);
`else
    chk("sb_hs_haz", obs_haz, 32'd1);
`endif
    md_v = 0;
    cycle();
    chk("sb_after_haz", obs_haz, 32'd0);
    issue = 1; issue_rd = 0; rs1 = 0;
    cycle();
    issue = 0;
    cycle();
    chk("sb_x0_haz", obs_haz, 32'd0);

    // Reset during WAIT with MD valid
    issue = 1; issue_rd = 9;
    cycle();
    issue = 0; rs1 = 9;
    md_v = 1; md_a = 9; md_d = 32'h99; alu_v = 1; alu_a = 2; alu_d = 2;
    cycle(); cycle();
    rst = 0;
    cycle();
    rst = 1; md_v = 0; alu_v = 0;
    cycle();
    chk("rstw_we", we, 32'd0);
    chk("rstw_haz", obs_haz, 32'd0);
    cycle();
    chk("rstw_we2", we, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      alu_v = $urandom_range(0, 1);
      alu_a = AW'($urandom); alu_d = $urandom;
      if (!md_have && $urandom_range(0, 2) == 0) begin
        md_have = 1; md_a = AW'($urandom_range(0, 7)); md_d = $urandom;
      end
      md_v = md_have;
      issue = ($urandom_range(0, 3) == 0);
      issue_rd = AW'($urandom_range(0, 7));
      rs1 = AW'($urandom_range(0, 7));
      rs2 = AW'($urandom_range(0, 7));
      rd  = AW'($urandom_range(0, 7));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
